// File: rtl/fcmp_operand_unpack.sv
// Operand unpacker for the FP compare unit: decodes two NaN-boxed operands into
// sign / rebiased exponent / hidden-bit mantissa / class flags behind a 2-entry elastic buffer.
`timescale 1ns/1ps

module fcmp_operand_unpack #(
  parameter int FLEN     = 64,
  parameter int NE       = 11,
  parameter int NF       = 52,
  parameter int NE1      = 8,
  parameter int NF1      = 23,
  parameter int BIAS_ADJ = 896
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic            Fmt,
  input  logic [FLEN-1:0] X,
  input  logic [FLEN-1:0] Y,
  output logic            OutValid,
  input  logic            OutReady,
  output logic            Xs,
  output logic            Ys,
  output logic [NE-1:0]   Xe,
  output logic [NE-1:0]   Ye,
  output logic [NF:0]     Xm,
  output logic [NF:0]     Ym,
  output logic            XZero,
  output logic            YZero,
  output logic            XInf,
  output logic            YInf,
  output logic            XNaN,
  output logic            YNaN,
  output logic            XSNaN,
  output logic            YSNaN,
  output logic            XSubnorm,
  output logic            YSubnorm,
  output logic            OutFmt
);

  localparam int SW = 1 + NE1 + NF1;  // single-precision container width

  typedef struct packed {
    logic          s;
    logic [NE-1:0] e;
    logic [NF:0]   m;
    logic          zero;
    logic          subnorm;
    logic          inf;
    logic          nan;
    logic          snan;
  } operand_t;

  typedef struct packed {
    operand_t x;
    operand_t y;
    logic     fmt;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  function automatic operand_t unpack_op(input logic [FLEN-1:0] raw, input logic dbl);
    operand_t       o;
    logic [NE-1:0]  e_biased;
    logic [NE1-1:0] e1;
    logic [NF-1:0]  f;
    logic           sign;
    logic           e_zero;
    logic           e_ones;
    logic           f_zero;
    o        = '0;
    e1       = raw[NE1+NF1-1 -: NE1];
    e_biased = '0;
    f        = '0;
    sign     = 1'b0;
    e_zero   = 1'b0;
    e_ones   = 1'b0;
    if (dbl) begin
      sign     = raw[FLEN-1];
      e_biased = raw[FLEN-2 -: NE];
      f        = raw[NF-1:0];
      e_zero   = (e_biased == '0);
      e_ones   = &e_biased;
    end else begin
      sign     = raw[SW-1];
      e_biased = {{(NE-NE1){1'b0}}, e1} + NE'(BIAS_ADJ);
      f        = {raw[NF1-1:0], {(NF-NF1){1'b0}}};
      e_zero   = (e1 == '0);
      e_ones   = &e1;
    end
    f_zero = (f == '0);

    if (!dbl && !(&raw[FLEN-1:SW])) begin
      // An unboxed single reads as the canonical quiet NaN.
      o.e   = '1;
      o.m   = {2'b11, {(NF-1){1'b0}}};
      o.nan = 1'b1;
    end else begin
      o.s       = sign;
      o.e       = e_zero ? '0 : (e_ones ? '1 : e_biased);
      o.m       = {!e_zero, f};
      o.zero    = e_zero & f_zero;
      o.subnorm = e_zero & !f_zero;
      o.inf     = e_ones & f_zero;
      o.nan     = e_ones & !f_zero;
      o.snan    = e_ones & !f_zero & !f[NF-1];
    end
    return o;
  endfunction

  entry_t dec_in;
  entry_t main_q;
  entry_t skid_q;
  state_t state;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   in_xfer;
  logic   out_xfer;

  always_comb begin
    dec_in.x   = unpack_op(X, Fmt);
    dec_in.y   = unpack_op(Y, Fmt);
    dec_in.fmt = Fmt;
  end

  assign in_xfer  = InValid & in_ready_q;
  assign out_xfer = out_valid_q & OutReady;

  // NOTE: every register here uses <= so all slots see the same pre-edge values;
  // the skid and main data are cleared on reset because their reset value is observable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (Flush) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q      <= dec_in;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_q     <= dec_in;
            state      <= TWO;
            in_ready_q <= 1'b0;
          end else if (out_xfer && !in_xfer) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end else if (in_xfer && out_xfer) begin
            main_q <= dec_in;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_q     <= skid_q;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign OutFmt   = main_q.fmt;
  assign Xs       = main_q.x.s;
  assign Xe       = main_q.x.e;
  assign Xm       = main_q.x.m;
  assign XZero    = main_q.x.zero;
  assign XSubnorm = main_q.x.subnorm;
  assign XInf     = main_q.x.inf;
  assign XNaN     = main_q.x.nan;
  assign XSNaN    = main_q.x.snan;
  assign Ys       = main_q.y.s;
  assign Ye       = main_q.y.e;
  assign Ym       = main_q.y.m;
  assign YZero    = main_q.y.zero;
  assign YSubnorm = main_q.y.subnorm;
  assign YInf     = main_q.y.inf;
  assign YNaN     = main_q.y.nan;
  assign YSNaN    = main_q.y.snan;

endmodule

// File: tb/tb_fcmp_operand_unpack.sv
// Directed self-checking bench for fcmp_operand_unpack: decode vectors, backpressure,
// back-to-back streaming, flush and reset mid-stream.
`timescale 1ns/1ps

module tb_fcmp_operand_unpack;

  logic        clk = 1'b0;
  logic        reset, Flush, InValid, InReady, Fmt, OutValid, OutReady;
  logic [63:0] X, Y;
  logic        Xs, Ys, OutFmt;
  logic [10:0] Xe, Ye;
  logic [52:0] Xm, Ym;
  logic        XZero, YZero, XInf, YInf, XNaN, YNaN, XSNaN, YSNaN, XSubnorm, YSubnorm;
  logic [4:0]  xflags, yflags;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fcmp_operand_unpack dut (
    .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .Fmt(Fmt), .X(X), .Y(Y), .OutValid(OutValid), .OutReady(OutReady),
    .Xs(Xs), .Ys(Ys), .Xe(Xe), .Ye(Ye), .Xm(Xm), .Ym(Ym),
    .XZero(XZero), .YZero(YZero), .XInf(XInf), .YInf(YInf), .XNaN(XNaN), .YNaN(YNaN),
    .XSNaN(XSNaN), .YSNaN(YSNaN), .XSubnorm(XSubnorm), .YSubnorm(YSubnorm), .OutFmt(OutFmt)
  );

  // {Zero, Subnorm, Inf, NaN, SNaN}
  assign xflags = {XZero, XSubnorm, XInf, XNaN, XSNaN};
  assign yflags = {YZero, YSubnorm, YInf, YNaN, YSNaN};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fmt, input logic [63:0] x, input logic [63:0] y);
    InValid = 1'b1;
    Fmt     = fmt;
    X       = x;
    Y       = y;
  endtask

  // Sends one pair into an empty block and leaves it presented on the outputs.
  task automatic send_one(input logic fmt, input logic [63:0] x, input logic [63:0] y);
    check("ready_before_send", 64'(InReady), 64'd1);
    drive(fmt, x, y);
    step();
    InValid = 1'b0;
    check("valid_after_send", 64'(OutValid), 64'd1);
  endtask

  // Tagged normal double: exponent 0x100+k, fraction k.
  function automatic logic [63:0] dbl(input int k);
    logic [63:0] r;
    r = {1'b0, 11'(256 + k), 52'(k)};
    return r;
  endfunction

  function automatic logic [63:0] exp_m(input int k);
    logic [63:0] r;
    r = (64'd1 << 52) | 64'(k);
    return r;
  endfunction

  task automatic check_pair(input string tag, input int k);
    check({tag, "_valid"}, 64'(OutValid), 64'd1);
    check({tag, "_xe"}, 64'(Xe), 64'(256 + k));
    check({tag, "_xm"}, 64'(Xm), exp_m(k));
    check({tag, "_ye"}, 64'(Ye), 64'(256 + k));
  endtask

  initial begin
    reset = 1'b0; Flush = 1'b0; InValid = 1'b0; Fmt = 1'b0;
    X = '0; Y = '0; OutReady = 1'b0;
    repeat (2) step();

    check("rst_valid", 64'(OutValid), 64'd0);
    check("rst_ready", 64'(InReady), 64'd1);
    check("rst_sign", 64'({Xs, Ys}), 64'd0);
    check("rst_exp", 64'({Xe, Ye}), 64'd0);
    check("rst_mant", 64'(Xm | Ym), 64'd0);
    check("rst_flags", 64'({xflags, yflags}), 64'd0);
    check("rst_fmt", 64'(OutFmt), 64'd0);
    reset    = 1'b1;
    OutReady = 1'b1;
    step();
    check("idle_valid", 64'(OutValid), 64'd0);

    // Double: 1.0 and -0.0
    send_one(1'b1, 64'h3FF0000000000000, 64'h8000000000000000);
    check("d_xs", 64'(Xs), 64'd0);
    check("d_xe", 64'(Xe), 64'h3FF);
    check("d_xm", 64'(Xm), 64'h10000000000000);
    check("d_xflags", 64'(xflags), 64'b00000);
    check("d_ys", 64'(Ys), 64'd1);
    check("d_ye", 64'(Ye), 64'd0);
    check("d_ym", 64'(Ym), 64'd0);
    check("d_yflags", 64'(yflags), 64'b10000);
    check("d_fmt", 64'(OutFmt), 64'd1);
    step();
    check("d_drained", 64'(OutValid), 64'd0);

    // Single: 1.0f and smallest subnormal
    send_one(1'b0, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF00000001);
    check("s_xe", 64'(Xe), 64'h3FF);
    check("s_xm", 64'(Xm), 64'h10000000000000);
    check("s_xflags", 64'(xflags), 64'b00000);
    check("s_ye", 64'(Ye), 64'd0);
    check("s_ym", 64'(Ym), 64'h0000000020000000);
    check("s_yflags", 64'(yflags), 64'b01000);
    check("s_fmt", 64'(OutFmt), 64'd0);
    step();

    // Unboxed single -> canonical qNaN; boxed single sNaN
    send_one(1'b0, 64'h000000003F800000, 64'hFFFFFFFF7F800001);
    check("n_xs", 64'(Xs), 64'd0);
    check("n_xe", 64'(Xe), 64'h7FF);
    check("n_xm", 64'(Xm), 64'h18000000000000);
    check("n_xflags", 64'(xflags), 64'b00010);
    check("n_ye", 64'(Ye), 64'h7FF);
    check("n_ym", 64'(Ym), 64'h10000020000000);
    check("n_yflags", 64'(yflags), 64'b00011);
    step();

    // Double +inf and negative double qNaN
    send_one(1'b1, 64'h7FF0000000000000, 64'hFFF8000000000000);
    check("i_xe", 64'(Xe), 64'h7FF);
    check("i_xm", 64'(Xm), 64'h10000000000000);
    check("i_xflags", 64'(xflags), 64'b00100);
    check("i_ys", 64'(Ys), 64'd1);
    check("i_ym", 64'(Ym), 64'h18000000000000);
    check("i_yflags", 64'(yflags), 64'b00010);
    step();

    // Single -2.0f (rebias 128 -> 1024) and +inf
    send_one(1'b0, 64'hFFFFFFFFC0000000, 64'hFFFFFFFF7F800000);
    check("r_xs", 64'(Xs), 64'd1);
    check("r_xe", 64'(Xe), 64'h400);
    check("r_xm", 64'(Xm), 64'h10000000000000);
    check("r_ye", 64'(Ye), 64'h7FF);
    check("r_ym", 64'(Ym), 64'h10000000000000);
    check("r_yflags", 64'(yflags), 64'b00100);
    step();

    // Backpressure: A, B accepted, C held until A leaves
    OutReady = 1'b0;
    drive(1'b1, dbl(1), dbl(1));
    step();
    check("bp_ready_one", 64'(InReady), 64'd1);
    check_pair("bp_a", 1);
    drive(1'b1, dbl(2), dbl(2));
    step();
    check("bp_ready_two", 64'(InReady), 64'd0);
    check_pair("bp_a_held", 1);
    drive(1'b1, dbl(3), dbl(3));
    step();
    check("bp_ready_full", 64'(InReady), 64'd0);
    check_pair("bp_a_stable", 1);
    OutReady = 1'b1;
    step();
    check_pair("bp_b", 2);
    check("bp_ready_back", 64'(InReady), 64'd1);
    step();
    InValid = 1'b0;
    check_pair("bp_c", 3);
    step();
    check("bp_drained", 64'(OutValid), 64'd0);

    // Back-to-back streaming from state ONE
    drive(1'b1, dbl(40), dbl(40));
    step();
    check_pair("st_first", 40);
    for (int k = 41; k <= 48; k++) begin
      drive(1'b1, dbl(k), dbl(k));
      step();
      check_pair("st", k);
      check("st_ready", 64'(InReady), 64'd1);
    end
    InValid = 1'b0;
    step();
    check("st_drained", 64'(OutValid), 64'd0);

    // Flush in state TWO with a new pair offered
    OutReady = 1'b0;
    drive(1'b1, dbl(20), dbl(20));
    step();
    drive(1'b1, dbl(21), dbl(21));
    step();
    check("fl_full", 64'(InReady), 64'd0);
    drive(1'b1, dbl(22), dbl(22));
    check("fl_ready_low", 64'(InReady), 64'd0);
    Flush = 1'b1;
    step();
    Flush   = 1'b0;
    InValid = 1'b0;
    check("fl_valid", 64'(OutValid), 64'd0);
    check("fl_ready", 64'(InReady), 64'd1);
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fl_quiet", 64'(OutValid), 64'd0);
    end

    // Same with reset low; data outputs must also clear
    OutReady = 1'b0;
    drive(1'b1, dbl(24), dbl(24));
    step();
    drive(1'b1, dbl(25), dbl(25));
    step();
    check("rs_full", 64'(InReady), 64'd0);
    drive(1'b1, dbl(26), dbl(26));
    reset = 1'b0;
    step();
    reset   = 1'b1;
    InValid = 1'b0;
    check("rs_valid", 64'(OutValid), 64'd0);
    check("rs_ready", 64'(InReady), 64'd1);
    check("rs_xe", 64'(Xe), 64'd0);
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rs_quiet", 64'(OutValid), 64'd0);
    end

    // Recovery after reset
    send_one(1'b1, dbl(30), dbl(30));
    check_pair("rec", 30);
    step();
    check("rec_drained", 64'(OutValid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
